// File: rtl/count_pwm_4bit_pkg.sv
// Shared definitions for the counter stages: default count width and PWM FSM encodings.
package count_pwm_4bit_pkg;

  localparam int unsigned COUNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } pwm_state_t;

endpackage

// File: rtl/count_pwm_4bit_wrap.sv
// Period-boundary detector for a free-running up-counter: flags the MAX -> 0 step only.
module count_wrap_detect
  import count_pwm_4bit_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] prev_count;

  // Reset clears prev_count, so no wrap is seen until a real MAX has been captured.
  always_ff @(posedge clk) begin
    if (rst) prev_count <= '0;
    else     prev_count <= count;
  end

  assign wrap = (prev_count == '1) && (count == '0);

endmodule

// File: rtl/count_pwm_4bit.sv
// PWM generator driven by an external up-counter, with shadowed duty updated at period boundaries.
module count_pwm_4bit
  import count_pwm_4bit_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  input  logic             pwm_en,
  input  logic             duty_wr,
  input  logic [WIDTH-1:0] duty_in,
  output logic             pwm_out,
  output logic             period_done,
  output logic             duty_pending,
  output logic             busy
);

  pwm_state_t       state, state_nxt;
  logic [WIDTH-1:0] duty_sh, duty_act, cmp_duty;
  logic             wrap, running, transfer;

  count_wrap_detect #(.WIDTH(WIDTH)) u_wrap (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .wrap  (wrap)
  );

  assign running  = (state == RUN) || (state == STOP);
  assign transfer = wrap && (state != IDLE);
  // On the wrap cycle duty_act is still the old value; the shadow is what takes effect now.
  assign cmp_duty = wrap ? duty_sh : duty_act;
  assign busy     = (state == ARM) || (state == RUN);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (pwm_en) state_nxt = ARM;
      ARM: begin
        if (!pwm_en)   state_nxt = IDLE;
        else if (wrap) state_nxt = RUN;
      end
      RUN:  if (!pwm_en) state_nxt = wrap ? IDLE : STOP;
      STOP: begin
        if (pwm_en)    state_nxt = RUN;
        else if (wrap) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      duty_sh      <= '0;
      duty_act     <= '0;
      duty_pending <= 1'b0;
      pwm_out      <= 1'b0;
      period_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      pwm_out     <= running && (count < cmp_duty);
      period_done <= running && wrap;
      if (transfer) duty_act <= duty_sh;
      // A write on the transfer cycle wins: the new value stays pending for the next period.
      if (duty_wr) begin
        duty_sh      <= duty_in;
        duty_pending <= 1'b1;
      end else if (transfer) begin
        duty_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_count_pwm_4bit.sv
// Self-checking bench for count_pwm_4bit: per-cycle scoreboard plus period-level scenarios.
module tb_count_pwm_4bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] count = '0;
  logic       pwm_en = 1'b0;
  logic       duty_wr = 1'b0;
  logic [3:0] duty_in = '0;
  logic       pwm_out, period_done, duty_pending, busy;

  int errors = 0;
  int checks = 0;

  count_pwm_4bit #(.WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .count        (count),
    .pwm_en       (pwm_en),
    .duty_wr      (duty_wr),
    .duty_in      (duty_in),
    .pwm_out      (pwm_out),
    .period_done  (period_done),
    .duty_pending (duty_pending),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Reference model state: 0 idle, 1 arm, 2 run, 3 stop.
  int       m_st = 0;
  int       m_prev = 0;
  int       m_sh = 0;
  int       m_act = 0;
  logic     m_pend = 1'b0;
  logic [3:0] sb[$];

  typedef struct {
    int duty;
    int first;
    int steady;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic w,
                      input logic [3:0] d, input logic [3:0] c);
    logic [3:0] exp_v, got;
    logic       wr, live, e_pwm, e_pd;
    int         nxt, dcmp;
    rst = r; pwm_en = e; duty_wr = w; duty_in = d; count = c;
    if (r) begin
      m_st = 0; m_prev = 0; m_sh = 0; m_act = 0; m_pend = 1'b0;
      exp_v = 4'b0000;
    end else begin
      wr    = (m_prev == 15) && (int'(c) == 0);
      live  = (m_st == 2) || (m_st == 3);
      dcmp  = wr ? m_sh : m_act;
      e_pwm = live && (int'(c) < dcmp);
      e_pd  = live && wr;
      if (wr && m_st != 0) begin m_act = m_sh; m_pend = 1'b0; end
      if (w) begin m_sh = int'(d); m_pend = 1'b1; end
      nxt = m_st;
      case (m_st)
        0: if (e) nxt = 1;
        1: if (!e) nxt = 0; else if (wr) nxt = 2;
        2: if (!e) nxt = wr ? 0 : 3;
        default: if (e) nxt = 2; else if (wr) nxt = 0;
      endcase
      m_st   = nxt;
      m_prev = int'(c);
      exp_v  = {e_pwm, e_pd, m_pend, (m_st == 1) || (m_st == 2)};
    end
    sb.push_back(exp_v);
    @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    got = {pwm_out, period_done, duty_pending, busy};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL cycle count=%0d rst=%0b: {pwm,pd,pend,busy} got %b expected %b",
               c, r, got, exp_v);
    end
  endtask

  task automatic run_period(input int off_at, input int on_at, input int wr_at,
                            input logic [3:0] wr_val, output int highs, output int pds,
                            output int pend_end);
    logic e;
    highs = 0; pds = 0;
    for (int i = 0; i < 16; i++) begin
      e = (i < off_at) || (i >= on_at);
      step(1'b0, e, i == wr_at, wr_val, 4'(i));
      highs += int'(pwm_out);
      pds   += int'(period_done);
    end
    pend_end = int'(duty_pending);
  endtask

  task automatic start_run(input logic [3:0] duty, output int first);
    int h, p, pe;
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    run_period(99, 99, 2, duty, h, p, pe);
    check("arm_low_highs", h, 0);
    run_period(99, 99, -1, 4'd0, first, p, pe);
  endtask

  initial begin
    int h, p, pe, first;
    tbl[0] = '{duty: 0,  first: 0,  steady: 0};
    tbl[1] = '{duty: 4,  first: 3,  steady: 4};
    tbl[2] = '{duty: 15, first: 14, steady: 15};
    tbl[3] = '{duty: 10, first: 9,  steady: 10};
    tbl[4] = '{duty: 1,  first: 0,  steady: 1};

    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    check("reset_outputs", int'({pwm_out, period_done, duty_pending, busy}), 0);
    step(1'b1, 1'b1, 1'b1, 4'd7, 4'd15);
    check("reset_holds", int'({pwm_out, period_done, duty_pending, busy}), 0);

    foreach (tbl[k]) begin
      start_run(4'(tbl[k].duty), first);
      check($sformatf("first_run_highs_d%0d", tbl[k].duty), first, tbl[k].first);
      for (int n = 0; n < 2; n++) begin
        run_period(99, 99, -1, 4'd0, h, p, pe);
        check($sformatf("steady_highs_d%0d", tbl[k].duty), h, tbl[k].steady);
        check($sformatf("period_done_d%0d", tbl[k].duty), p, 1);
      end
    end

    // Duty write mid-period takes effect only after the next wrap.
    start_run(4'd4, first);
    run_period(99, 99, 7, 4'd10, h, p, pe);
    check("midwrite_keep_highs", h, 4);
    check("midwrite_pending", pe, 1);
    run_period(99, 99, -1, 4'd0, h, p, pe);
    check("midwrite_new_highs", h, 10);
    check("midwrite_pending_clr", pe, 0);

    // Duty write on the wrap cycle itself.
    start_run(4'd6, first);
    run_period(99, 99, 0, 4'd12, h, p, pe);
    check("wrapwrite_old_highs", h, 6);
    check("wrapwrite_pending", pe, 1);
    run_period(99, 99, -1, 4'd0, h, p, pe);
    check("wrapwrite_new_highs", h, 12);
    check("wrapwrite_pending_clr", pe, 0);

    // Stop request completes the period, then one period_done on the terminating wrap.
    start_run(4'd4, first);
    run_period(5, 99, -1, 4'd0, h, p, pe);
    check("stop_period_highs", h, 4);
    run_period(0, 99, -1, 4'd0, h, p, pe);
    check("stop_final_pd", p, 1);
    check("stop_wrap_highs", h, 1);
    check("stop_idle_pwm", int'(pwm_out), 0);
    check("stop_idle_busy", int'(busy), 0);

    // Re-enable while in STOP resumes RUN without waiting for a wrap.
    start_run(4'd4, first);
    run_period(5, 9, -1, 4'd0, h, p, pe);
    check("resume_busy", int'(busy), 1);
    run_period(99, 99, -1, 4'd0, h, p, pe);
    check("resume_highs", h, 4);
    check("resume_pd", p, 1);

    // Held count keeps the compare result; reset mid-period emits nothing.
    start_run(4'd12, first);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 4'd0, 4'(i));
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0, 4'd9);
      check("hold_pwm", int'(pwm_out), 1);
      check("hold_no_pd", int'(period_done), 0);
    end
    step(1'b1, 1'b1, 1'b1, 4'd3, 4'd9);
    check("midreset_outputs", int'({pwm_out, period_done, duty_pending, busy}), 0);
    p = 0;
    for (int i = 10; i < 17; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'd0, 4'(i % 16));
      p += int'(period_done);
    end
    check("midreset_no_pd", p, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
